// File: rtl/turn_signal_ctrl_pkg.sv
// turn_ctrl_pkg: shared defaults, contact indices and helpers for the
// turn-signal input conditioning block.
// Optional feature macro: TURN_AUTO_CANCEL_EN (see turn_signal_ctrl.sv).
package turn_ctrl_pkg;

  // Default configuration values
  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 4;
  localparam int unsigned DEF_TICK_DIV          = 8;
  localparam int unsigned DEF_AUTO_CANCEL_STEPS = 32;

  // Contact positions inside the debouncer bank
  localparam int unsigned IDX_LEFT     = 0;
  localparam int unsigned IDX_RIGHT    = 1;
  localparam int unsigned IDX_HAZARD   = 2;
  localparam int unsigned NUM_CONTACTS = 3;

  // Registered request bundle presented to the lamp sequencer
  typedef struct packed {
    logic emergency;
    logic turn_left;
    logic turn_right;
  } lamp_req_t;

  // Bits needed for a counter that must hold values 0..max_val
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/turn_signal_ctrl_if.sv
// turn_signal_ctrl_if: raw driver contacts in, conditioned sequencer
// requests out. master = contact/sequencer side, slave = controller.
interface turn_signal_ctrl_if;
  logic STALK_LEFT_RAW;
  logic STALK_RIGHT_RAW;
  logic HAZARD_BTN_RAW;
  logic EMERGENCY;
  logic TURN_LEFT;
  logic TURN_RIGHT;
  logic STEP_TICK;

  modport master (
    output STALK_LEFT_RAW, STALK_RIGHT_RAW, HAZARD_BTN_RAW,
    input  EMERGENCY, TURN_LEFT, TURN_RIGHT, STEP_TICK
  );

  modport slave (
    input  STALK_LEFT_RAW, STALK_RIGHT_RAW, HAZARD_BTN_RAW,
    output EMERGENCY, TURN_LEFT, TURN_RIGHT, STEP_TICK
  );
endinterface

// File: rtl/switch_debounce.sv
// switch_debounce: 2-flop synchronizer followed by a stability counter.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive
// synchronized samples that disagree with it.
module switch_debounce
  import turn_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_db
);

  localparam int unsigned W = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0] LP_LAST = W'(DEBOUNCE_CYCLES - 1);

  logic         r_sync1;
  logic         r_sync2;
  logic         r_db;
  logic [W-1:0] r_cnt;

  // Synchronize the raw contact and qualify changes against the debounced level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_LAST) begin
        r_db  <= ~r_db;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/turn_signal_ctrl.sv
// turn_signal_ctrl: conditions stalk and hazard contacts for the tail-lamp
// sequencer: debounce, hazard toggle latch, left/right conflict resolution,
// hazard priority and a free-running STEP_TICK divider.
// Optional feature macro: TURN_AUTO_CANCEL_EN -- cancels a turn request that
// has been held for AUTO_CANCEL_STEPS step ticks until the stalk is released.
module turn_signal_ctrl
  import turn_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned TICK_DIV          = DEF_TICK_DIV,
  parameter int unsigned AUTO_CANCEL_STEPS = DEF_AUTO_CANCEL_STEPS
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  turn_signal_ctrl_if.slave  bus
);

  localparam int unsigned DW = cnt_width(TICK_DIV - 1);
  localparam logic [DW-1:0] LP_DIV_LAST = DW'(TICK_DIV - 1);

  logic [NUM_CONTACTS-1:0] w_raw;
  logic [NUM_CONTACTS-1:0] w_db;
  logic                    w_haz_rise;
  logic                    w_haz_next;
  logic [1:0]              w_req;
  logic [1:0]              w_cancel;
  logic [DW-1:0]           w_div_next;
  lamp_req_t               w_next;

  logic                    r_haz_db_d;
  logic                    r_hazard;
  logic [1:0]              r_turn;
  logic [DW-1:0]           r_div;
  logic                    r_tick;

  assign w_raw[IDX_LEFT]   = bus.STALK_LEFT_RAW;
  assign w_raw[IDX_RIGHT]  = bus.STALK_RIGHT_RAW;
  assign w_raw[IDX_HAZARD] = bus.HAZARD_BTN_RAW;

  genvar gi;

  // One synchronizer/debouncer per contact
  generate
    for (gi = 0; gi < NUM_CONTACTS; gi++) begin : g_db
      switch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
        .i_clk   (CLOCK),
        .i_rst_n (RESET_N),
        .i_raw   (w_raw[gi]),
        .o_db    (w_db[gi])
      );
    end
  endgenerate

  // The latch toggles on the press edge only; holding or releasing does nothing.
  // Its next value is used for turn masking so both change on the same edge.
  assign w_haz_rise = w_db[IDX_HAZARD] & ~r_haz_db_d;
  assign w_haz_next = r_hazard ^ w_haz_rise;

  // Conflicting stalks cancel each other
  assign w_req[IDX_LEFT]  = w_db[IDX_LEFT]  & ~w_db[IDX_RIGHT];
  assign w_req[IDX_RIGHT] = w_db[IDX_RIGHT] & ~w_db[IDX_LEFT];

  assign w_div_next = (r_div == LP_DIV_LAST) ? '0 : r_div + 1'b1;

`ifdef TURN_AUTO_CANCEL_EN
  localparam int unsigned CW = cnt_width(AUTO_CANCEL_STEPS);
  localparam logic [CW-1:0] LP_CANCEL_LAST = CW'(AUTO_CANCEL_STEPS - 1);

  // Per-side step counter and sticky cancel flag
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cancel
      logic [CW-1:0] r_cnt;
      logic          r_flag;
      logic          w_expire;

      assign w_expire     = r_turn[gi] & r_tick & ~w_haz_next & (r_cnt == LP_CANCEL_LAST);
      assign w_cancel[gi] = r_flag | w_expire;

      // Count ticks while the side is lit; flag stays set until the stalk drops
      always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
          r_cnt  <= '0;
          r_flag <= 1'b0;
        end else begin
          if (!r_turn[gi] || w_haz_next) begin
            r_cnt <= '0;
          end else if (r_tick) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (!w_db[gi]) begin
            r_flag <= 1'b0;
          end else if (w_expire) begin
            r_flag <= 1'b1;
          end
        end
      end
    end
  endgenerate
`else
  // Cancel logic not built: AUTO_CANCEL_STEPS has no effect here
  assign w_cancel = (AUTO_CANCEL_STEPS > 0) ? 2'b00 : 2'b00;
`endif

  // Next request bundle with hazard priority
  always_comb begin
    w_next            = '0;
    w_next.emergency  = w_haz_next;
    w_next.turn_left  = w_req[IDX_LEFT]  & ~w_haz_next & ~w_cancel[IDX_LEFT];
    w_next.turn_right = w_req[IDX_RIGHT] & ~w_haz_next & ~w_cancel[IDX_RIGHT];
  end

  // Output registers, hazard latch and free-running step divider
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_haz_db_d <= 1'b0;
      r_hazard   <= 1'b0;
      r_turn     <= 2'b00;
      r_div      <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_haz_db_d        <= w_db[IDX_HAZARD];
      r_hazard          <= w_next.emergency;
      r_turn[IDX_LEFT]  <= w_next.turn_left;
      r_turn[IDX_RIGHT] <= w_next.turn_right;
      r_div             <= w_div_next;
      r_tick            <= (w_div_next == LP_DIV_LAST);
    end
  end

  assign bus.EMERGENCY  = r_hazard;
  assign bus.TURN_LEFT  = r_turn[IDX_LEFT];
  assign bus.TURN_RIGHT = r_turn[IDX_RIGHT];
  assign bus.STEP_TICK  = r_tick;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// tb_turn_signal_ctrl: directed test of turn_signal_ctrl at default
// debounce/divider settings, AUTO_CANCEL_STEPS = 4.
// Output vectors are written {EMERGENCY, TURN_LEFT, TURN_RIGHT}.
module tb_turn_signal_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  turn_signal_ctrl_if bus ();

  turn_signal_ctrl #(
    .DEBOUNCE_CYCLES   (4),
    .TICK_DIV          (8),
    .AUTO_CANCEL_STEPS (4)
  ) dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [2:0] outs();
    return {bus.EMERGENCY, bus.TURN_LEFT, bus.TURN_RIGHT};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Input was just changed on a negedge: outputs hold for 6 edges, change after the 7th
  task automatic lat_check(input string tag, input logic [2:0] old_v, input logic [2:0] new_v);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {29'd0, outs()}, {29'd0, old_v});
    end
    @(negedge clk);
    chk(tag, {29'd0, outs()}, {29'd0, new_v});
    $display("step %s: outputs %b -> %b", tag, old_v, outs());
  endtask

  task automatic steady(input string tag, input logic [2:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk(tag, {29'd0, outs()}, {29'd0, v});
    end
    $display("step %s: held %b for %0d cycles", tag, v, n);
  endtask

  initial begin
    int ticks;
    int cyc;
    n_cmp = 0;
    n_err = 0;

    // Reset with all contacts asserted
    rst_n = 1'b0;
    bus.STALK_LEFT_RAW  = 1'b1;
    bus.STALK_RIGHT_RAW = 1'b1;
    bus.HAZARD_BTN_RAW  = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_outs", {29'd0, outs()}, 32'd0);
    chk("rst_tick", {31'd0, bus.STEP_TICK}, 32'd0);
    $display("step reset: outs=%b tick=%b", outs(), bus.STEP_TICK);

    // Release with contacts idle: ticks in cycles 8, 16, 24
    bus.STALK_LEFT_RAW  = 1'b0;
    bus.STALK_RIGHT_RAW = 1'b0;
    bus.HAZARD_BTN_RAW  = 1'b0;
    rst_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      chk("tick_phase", {31'd0, bus.STEP_TICK}, {31'd0, ((k % 8) == 7)});
      chk("idle_outs", {29'd0, outs()}, 32'd0);
    end
    $display("step tick: 24 cycles after release checked");

    // Bounce: 2-cycle pulses never qualify
    for (int p = 0; p < 4; p++) begin
      bus.STALK_LEFT_RAW = (p % 2 == 0);
      repeat (2) begin
        @(negedge clk);
        chk("bounce", {29'd0, outs()}, 32'd0);
      end
    end
    bus.STALK_LEFT_RAW = 1'b1;
    lat_check("left_rise", 3'b000, 3'b010);
    steady("left_on", 3'b010, 5);
    bus.STALK_LEFT_RAW = 1'b0;
    lat_check("left_fall", 3'b010, 3'b000);

    // Conflict resolution
    bus.STALK_LEFT_RAW = 1'b1;
    lat_check("conf_left", 3'b000, 3'b010);
    bus.STALK_RIGHT_RAW = 1'b1;
    lat_check("conf_both", 3'b010, 3'b000);
    steady("conf_both_hold", 3'b000, 5);
    bus.STALK_LEFT_RAW = 1'b0;
    lat_check("conf_right", 3'b000, 3'b001);
    bus.STALK_RIGHT_RAW = 1'b0;
    lat_check("right_fall", 3'b001, 3'b000);

    // Hazard toggling with left held
    bus.STALK_LEFT_RAW = 1'b1;
    lat_check("haz_left", 3'b000, 3'b010);
    bus.HAZARD_BTN_RAW = 1'b1;
    lat_check("haz_on", 3'b010, 3'b100);
    repeat (3) @(negedge clk);
    bus.HAZARD_BTN_RAW = 1'b0;
    steady("haz_release", 3'b100, 12);
    bus.HAZARD_BTN_RAW = 1'b1;
    lat_check("haz_off", 3'b100, 3'b010);
    repeat (3) @(negedge clk);
    bus.HAZARD_BTN_RAW = 1'b0;
    steady("haz_off_hold", 3'b010, 12);
    bus.HAZARD_BTN_RAW = 1'b1;
    repeat (3) @(negedge clk);
    bus.HAZARD_BTN_RAW = 1'b0;
    steady("haz_short", 3'b010, 12);
    bus.STALK_LEFT_RAW = 1'b0;
    lat_check("haz_left_off", 3'b010, 3'b000);

    // Held right stalk
    bus.STALK_RIGHT_RAW = 1'b1;
    lat_check("ac_right", 3'b000, 3'b001);
`ifdef TURN_AUTO_CANCEL_EN
    ticks = 0;
    cyc = 0;
    while (ticks < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.STEP_TICK && bus.TURN_RIGHT) ticks++;
    end
    chk("ac_ticks", ticks, 4);
    @(negedge clk);
    chk("ac_cancel", {29'd0, outs()}, 32'd0);
    steady("ac_cancel_hold", 3'b000, 20);
    bus.STALK_RIGHT_RAW = 1'b0;
    steady("ac_release", 3'b000, 10);
    bus.STALK_RIGHT_RAW = 1'b1;
    lat_check("ac_repress", 3'b000, 3'b001);
`else
    ticks = 0;
    cyc = 0;
    while (ticks < 100 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      chk("no_ac_hold", {29'd0, outs()}, 32'd1);
      if (bus.STEP_TICK) ticks++;
    end
    chk("no_ac_ticks", ticks, 100);
    $display("step no_auto_cancel: right held over %0d ticks", ticks);
`endif
    bus.STALK_RIGHT_RAW = 1'b0;
    lat_check("ac_right_off", 3'b001, 3'b000);

    // Asynchronous reset in the middle of a hazard
    bus.HAZARD_BTN_RAW = 1'b1;
    lat_check("mid_haz_on", 3'b000, 3'b100);
    repeat (3) @(negedge clk);
    bus.HAZARD_BTN_RAW = 1'b0;
    steady("mid_haz_hold", 3'b100, 5);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {29'd0, outs()}, 32'd0);
    chk("async_rst_tick", {31'd0, bus.STEP_TICK}, 32'd0);
    $display("step async_reset: outs=%b", outs());
    @(negedge clk);
    rst_n = 1'b1;
    steady("post_rst", 3'b000, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/turn_signal_ctrl.md
# turn_signal_ctrl

Driver-input conditioning stage that sits directly upstream of the tail-lamp sequencer. It synchronizes and debounces the raw turn-stalk and hazard-button contacts, and latches hazard on/off from button presses. It resolves conflicting requests and generates the free-running step tick that paces the lamp sequence. Outputs are clean, registered levels that connect straight to the sequencer's EMERGENCY, TURN_LEFT and TURN_RIGHT inputs.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a contact change (≥2).
- TICK_DIV, 8: STEP_TICK period in CLOCK cycles (≥2).
- AUTO_CANCEL_STEPS, 32: STEP_TICK count after which a held turn request is cancelled (≥1). Used only when the auto-cancel feature is compiled in.
- CLOCK  input  1  single system clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- STALK_LEFT_RAW  input  1  raw left stalk contact, asynchronous level, may bounce.
- STALK_RIGHT_RAW  input  1  raw right stalk contact, asynchronous level, may bounce.
- HAZARD_BTN_RAW  input  1  raw momentary hazard push-button, asynchronous, may bounce.
- EMERGENCY  output  1  hazard latch state, registered.
- TURN_LEFT  output  1  conditioned left request, registered.
- TURN_RIGHT  output  1  conditioned right request, registered.
- STEP_TICK  output  1  single-cycle pacing pulse for the sequencer, registered.

## Operation
- Each raw input passes through a 2-flop synchronizer, then a debouncer.
- Debouncer: holds a debounced value `db` and a counter.
  - While the synchronized sample equals `db`, the counter is cleared.
  - While the sample differs, the counter increments.
  - On the cycle where the counter equals DEBOUNCE_CYCLES-1 and the sample still differs, `db` flips and the counter clears.
- Hazard latch: a rising edge of debounced HAZARD (`db` going 0→1) toggles the latch. Release does nothing. Holding the button produces one toggle only.
- Turn resolution, evaluated every cycle:
  - left_req = dbL & ~dbR; right_req = dbR & ~dbL.
  - If both stalks are asserted, both requests are 0.
- Priority: while the hazard latch is 1, TURN_LEFT = TURN_RIGHT = 0 and EMERGENCY = 1. When hazard clears, turn outputs resume from the current stalk state with no re-press needed.
- STEP_TICK:
  - A divider counts 0..TICK_DIV-1 and wraps.
  - STEP_TICK is high for exactly one cycle per wrap.
  - The divider is free-running and independent of the inputs.
- All outputs are driven from flops. There are no combinational paths from input to output.

## Timing
- Reset (RESET_N low, asynchronous) sets all of the following to 0: synchronizers, debounced values, debounce counters, hazard latch, divider, cancel state, and all four outputs.
  - Reset takes effect immediately, including mid-hazard or mid-turn.
  - After release, outputs stay 0 until the inputs re-qualify through the full debounce latency.
- Latency: take the first rising edge that samples a new raw level as edge 1. The corresponding output changes after edge DEBOUNCE_CYCLES+3 (7 cycles at the default), provided the raw level is held throughout.
- Any raw pulse or glitch shorter than DEBOUNCE_CYCLES synchronized samples never reaches an output.
- The hazard toggle appears on EMERGENCY with the same latency as a turn change.
- Simultaneous events:
  - A hazard toggle and a stalk change qualifying on the same cycle both take effect on the same output edge; hazard priority applies.
  - Both stalks qualifying together yields no turn output.
- STEP_TICK:
  - First pulse occurs in cycle TICK_DIV after reset release (the divider equals TICK_DIV-1).
  - Subsequent pulses occur exactly TICK_DIV cycles apart.
  - STEP_TICK is never high on two consecutive cycles.

## Configuration
- Macro TURN_AUTO_CANCEL_EN.
- Defined:
  - A per-side counter counts STEP_TICKs while that side's turn output is 1.
  - When the count reaches AUTO_CANCEL_STEPS, that output is forced to 0 and a cancel flag is set.
  - The flag clears only when that side's debounced stalk returns to 0; re-assertion then passes normally.
  - The counter clears whenever the output is 0 or hazard is active.
  - Counter width is $clog2(AUTO_CANCEL_STEPS+1).
- Undefined: no cancel logic. Turn outputs follow the resolved stalk state indefinitely. AUTO_CANCEL_STEPS is ignored.

## Structure
- Package turn_ctrl_pkg holds:
  - default values for DEBOUNCE_CYCLES, TICK_DIV and AUTO_CANCEL_STEPS;
  - a localparam function for counter width.
- Sub-module switch_debounce (2-flop synchronizer plus debounce counter, parameter DEBOUNCE_CYCLES) is instantiated three times: left, right, hazard.
- The top level contains the hazard edge detect and latch, turn resolution, divider, optional cancel logic, and output registers.

## Test plan
All scenarios use the defaults, with AUTO_CANCEL_STEPS=4 where auto-cancel applies.
- Reset: hold RESET_N low with all raw inputs at 1 → all outputs 0. Release with inputs at 0 → STEP_TICK pulses at cycles 8, 16, 24; other outputs remain 0.
- Bounce: STALK_LEFT_RAW toggles 1,0,1,0 in 2-cycle pulses, then is held at 1 → no output during the bounce; TURN_LEFT rises exactly 7 edges after the final 0→1 is first sampled. Dropping the stalk falls TURN_LEFT 7 edges later.
- Conflict: left qualified (TURN_LEFT=1), then right asserted and held → after the latency, TURN_LEFT=0 and TURN_RIGHT=0. Releasing left → TURN_RIGHT=1 after the latency.
- Hazard: left held (TURN_LEFT=1); press HAZARD_BTN_RAW for 10 cycles → EMERGENCY=1 and TURN_LEFT=0 on the same edge. A second press → EMERGENCY=0 and TURN_LEFT=1 on the same edge. A 3-cycle press → no toggle.
- Auto-cancel (TURN_AUTO_CANCEL_EN defined): right held → TURN_RIGHT falls after its 4th STEP_TICK and stays 0 while held. Release and re-press → TURN_RIGHT=1 again. With the macro undefined, the same stimulus keeps TURN_RIGHT=1 for 100 ticks.
- Reset mid-operation: EMERGENCY=1, then pulse RESET_N low for 1 cycle → EMERGENCY=0 immediately. It stays 0 after release with the button untouched.
